// File: rtl/kch_pkg.sv
// Shared types and defaults for the KCH collection-window controller.
package kch_pkg;

   localparam int KCH_WORD_WIDTH = 16;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_EVAL    = 2'd2,
      S_OUTPUT  = 2'd3
   } kch_state_e;

   typedef struct packed {
      logic [KCH_WORD_WIDTH-1:0] id;
      logic [KCH_WORD_WIDTH-1:0] hops;
      logic [KCH_WORD_WIDTH-1:0] qvalue;
   } ch_info_t;

endpackage

// File: rtl/kch_window_ctrl_timeout.sv
// Inactivity timer for the collection window: load to TIMEOUT_CYCLES, count down, flag terminal count.
module kch_timeout_ctr #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic nrst,
   input  logic load,
   input  logic dec,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         count <= '0;
      else if (load)
         count <= CW'(TIMEOUT_CYCLES);
      else if (dec && count != '0)
         count <= count - CW'(1);
   end

   // Terminal count is 1 so the window spans exactly TIMEOUT_CYCLES idle cycles.
   assign expire = (count == CW'(1));

endmodule

// File: rtl/kch_window_ctrl.sv
// One KCH collection window per heartbeat: open, forward adverts to the selector, close, report the best CH.
//  state     | meaning
//  S_IDLE    | no round active, adverts refused
//  S_COLLECT | window open, adverts accepted and forwarded as sel_en pulses
//  S_EVAL    | window closed, waiting SEL_LATENCY cycles for the selector to settle
//  S_OUTPUT  | result held on res_valid until the consumer takes it
module kch_window_ctrl
   import kch_pkg::*;
#(
   parameter int WORD_WIDTH     = KCH_WORD_WIDTH,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int SEL_LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  hb_start,
   input  logic [WORD_WIDTH-1:0] hb_chlimit,
   input  logic                  adv_valid,
   output logic                  adv_ready,
   input  logic [WORD_WIDTH-1:0] adv_id,
   input  logic [WORD_WIDTH-1:0] adv_hops,
   input  logic [WORD_WIDTH-1:0] adv_qvalue,
   output logic                  sel_clear,
   output logic                  sel_en,
   output logic [WORD_WIDTH-1:0] sel_id,
   output logic [WORD_WIDTH-1:0] sel_hops,
   output logic [WORD_WIDTH-1:0] sel_q,
   input  logic [WORD_WIDTH-1:0] sel_chosen,
   input  logic [WORD_WIDTH-1:0] sel_hopsch,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [WORD_WIDTH-1:0] chosenCH,
   output logic [WORD_WIDTH-1:0] hopsfromCH,
   output logic                  no_ch,
   output logic [WORD_WIDTH-1:0] adv_count
);

   localparam int LW = $clog2(SEL_LATENCY + 1);

   kch_state_e            state;
   logic [WORD_WIDTH-1:0] limit;
   logic [WORD_WIDTH-1:0] cnt_inc;
   logic [LW-1:0]         lat_cnt;
   logic                  accept;
   logic                  limit_hit;
   logic                  expire;
   logic                  timer_load;
   logic                  timer_dec;
   logic                  eval_done;

   assign adv_ready  = (state == S_COLLECT) && !hb_start;
   assign accept     = adv_valid && adv_ready;
   assign cnt_inc    = (adv_count == '1) ? adv_count : adv_count + WORD_WIDTH'(1);
   assign limit_hit  = (limit != '0) && (cnt_inc == limit);
   assign timer_load = hb_start || accept;
   assign timer_dec  = (state == S_COLLECT) && !timer_load;
   // A sel_en still in flight restarts the settle count, so EVAL always waits after the final sample.
   assign eval_done  = (state == S_EVAL) && !sel_en && (lat_cnt == LW'(1));

   kch_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk    (clk),
      .nrst   (nrst),
      .load   (timer_load),
      .dec    (timer_dec),
      .expire (expire)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         state <= S_IDLE;
      else if (hb_start)
         state <= S_COLLECT;
      else begin
         case (state)
            S_IDLE:    state <= S_IDLE;
            S_COLLECT: if (accept ? limit_hit : expire) state <= S_EVAL;
            S_EVAL:    if (eval_done) state <= S_OUTPUT;
            S_OUTPUT:  if (res_ready) state <= S_IDLE;
            default:   state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sel_clear  <= 1'b0;
         sel_en     <= 1'b0;
         sel_id     <= '0;
         sel_hops   <= '0;
         sel_q      <= '0;
         res_valid  <= 1'b0;
         chosenCH   <= '1;
         hopsfromCH <= '1;
         no_ch      <= 1'b0;
         adv_count  <= '0;
         limit      <= '0;
         lat_cnt    <= LW'(SEL_LATENCY);
      end else begin
         sel_clear <= hb_start;
         sel_en    <= accept;
         if (accept) begin
            sel_id   <= adv_id;
            sel_hops <= adv_hops;
            sel_q    <= adv_qvalue;
         end

         if (state != S_EVAL || sel_en)
            lat_cnt <= LW'(SEL_LATENCY);
         else if (lat_cnt != LW'(1))
            lat_cnt <= lat_cnt - LW'(1);

         if (hb_start) begin
            limit     <= hb_chlimit;
            adv_count <= '0;
            no_ch     <= 1'b0;
            res_valid <= 1'b0;
         end else begin
            if (accept)
               adv_count <= cnt_inc;
            if (eval_done) begin
               res_valid <= 1'b1;
               if (adv_count == '0) begin
                  no_ch      <= 1'b1;
                  chosenCH   <= '1;
                  hopsfromCH <= '1;
               end else begin
                  chosenCH   <= sel_chosen;
                  hopsfromCH <= sel_hopsch;
               end
            end
            if (state == S_OUTPUT && res_ready)
               res_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_kch_window_ctrl.sv
// Scoreboard bench for kch_window_ctrl: directed rounds, queued expectations, monitors on sel_en and result handshake.
module tb_kch_window_ctrl;
   import kch_pkg::*;

   localparam int WW = 16;
   localparam int T  = 64;
   localparam int L  = 2;

   typedef struct packed {
      logic [WW-1:0] ch;
      logic [WW-1:0] hops;
      logic          noch;
      logic [WW-1:0] cnt;
   } res_t;

   logic          clk = 1'b0;
   logic          nrst;
   logic          hb_start;
   logic [WW-1:0] hb_chlimit;
   logic          adv_valid;
   logic          adv_ready;
   logic [WW-1:0] adv_id, adv_hops, adv_qvalue;
   logic          sel_clear, sel_en;
   logic [WW-1:0] sel_id, sel_hops, sel_q;
   logic [WW-1:0] sel_chosen, sel_hopsch;
   logic          res_valid, res_ready;
   logic [WW-1:0] chosenCH, hopsfromCH;
   logic          no_ch;
   logic [WW-1:0] adv_count;

   ch_info_t sel_exp[$];
   res_t     res_exp[$];
   ch_info_t se;
   res_t     re;
   int total = 0;
   int bad = 0;
   int res_seen = 0;
   int sel_seen = 0;

   kch_window_ctrl #(.WORD_WIDTH(WW), .TIMEOUT_CYCLES(T), .SEL_LATENCY(L)) dut (
      .clk(clk), .nrst(nrst), .hb_start(hb_start), .hb_chlimit(hb_chlimit),
      .adv_valid(adv_valid), .adv_ready(adv_ready), .adv_id(adv_id), .adv_hops(adv_hops),
      .adv_qvalue(adv_qvalue), .sel_clear(sel_clear), .sel_en(sel_en), .sel_id(sel_id),
      .sel_hops(sel_hops), .sel_q(sel_q), .sel_chosen(sel_chosen), .sel_hopsch(sel_hopsch),
      .res_valid(res_valid), .res_ready(res_ready), .chosenCH(chosenCH),
      .hopsfromCH(hopsfromCH), .no_ch(no_ch), .adv_count(adv_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (nrst && sel_en) begin
         check("sel_en_with_clear", sel_clear, 1'b0);
         if (sel_exp.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sel_unexpected: got sel_en id=%0h, required no pulse", sel_id);
         end else begin
            se = sel_exp.pop_front();
            check("sel_id", sel_id, se.id);
            check("sel_hops", sel_hops, se.hops);
            check("sel_q", sel_q, se.qvalue);
         end
         sel_seen++;
      end
   end

   always @(negedge clk) begin
      if (nrst && res_valid && res_ready) begin
         if (res_exp.size() == 0) begin
            total++;
            bad++;
            $display("FAIL res_unexpected: got result ch=%0h, required none", chosenCH);
         end else begin
            re = res_exp.pop_front();
            check("res_chosen", chosenCH, re.ch);
            check("res_hops", hopsfromCH, re.hops);
            check("res_no_ch", no_ch, re.noch);
            check("res_count", adv_count, re.cnt);
         end
         res_seen++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, required finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hb(input logic [WW-1:0] lim);
      hb_start   = 1'b1;
      hb_chlimit = lim;
      tick();
      hb_start = 1'b0;
   endtask

   task automatic drive_adv(input ch_info_t a);
      adv_valid  = 1'b1;
      adv_id     = a.id;
      adv_hops   = a.hops;
      adv_qvalue = a.qvalue;
   endtask

   task automatic wait_res(input int target, input int budget, input string name);
      int n = 0;
      while (res_seen < target && n < budget) begin
         tick();
         n++;
      end
      total++;
      if (res_seen < target) begin
         bad++;
         $display("FAIL %s: got %0d results, required %0d", name, res_seen, target);
      end
   endtask

   initial begin
      ch_info_t a;
      logic     rdy [4];
      int       n;
      int       base;

      nrst = 1'b0; hb_start = 1'b0; hb_chlimit = '0; adv_valid = 1'b0;
      adv_id = '0; adv_hops = '0; adv_qvalue = '0;
      sel_chosen = '0; sel_hopsch = '0; res_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 nrst = 1'b1;
      @(negedge clk);
      check("rst_adv_ready", adv_ready, 1'b0);
      check("rst_res_valid", res_valid, 1'b0);
      check("rst_chosen", chosenCH, 16'hFFFF);
      check("rst_hops", hopsfromCH, 16'hFFFF);
      check("rst_sel_en", sel_en, 1'b0);
      check("rst_sel_clear", sel_clear, 1'b0);
      check("rst_no_ch", no_ch, 1'b0);
      check("rst_count", adv_count, 16'd0);

      // round with three adverts, closed by timeout
      tick();
      sel_chosen = 16'd9; sel_hopsch = 16'd1; res_ready = 1'b1;
      hb(16'd0);
      @(negedge clk);
      check("t1_sel_clear", sel_clear, 1'b1);
      check("t1_count0", adv_count, 16'd0);
      tick();
      for (int i = 0; i < 3; i++) begin
         case (i)
            0:       a = ch_info_t'{id: 16'd5, hops: 16'd2, qvalue: 16'd10};
            1:       a = ch_info_t'{id: 16'd2, hops: 16'd1, qvalue: 16'd20};
            default: a = ch_info_t'{id: 16'd9, hops: 16'd1, qvalue: 16'd30};
         endcase
         sel_exp.push_back(a);
         drive_adv(a);
         tick();
         adv_valid = 1'b0;
         tick();
      end
      res_exp.push_back(res_t'{ch: 16'd9, hops: 16'd1, noch: 1'b0, cnt: 16'd3});
      wait_res(1, 150, "t1_result_wait");
      tick();
      check("t1_res_dropped", res_valid, 1'b0);

      // limit of 2 with four back-to-back adverts
      sel_chosen = 16'h0033; sel_hopsch = 16'h0004;
      base = sel_seen;
      hb(16'd2);
      for (int i = 0; i < 4; i++) begin
         a = ch_info_t'{id: WW'(16'h20 + i), hops: WW'(i + 1), qvalue: WW'(16'h40 + i)};
         if (i < 2) sel_exp.push_back(a);
         drive_adv(a);
         @(negedge clk);
         rdy[i] = adv_ready;
         tick();
      end
      adv_valid = 1'b0;
      check("t2_ready0", rdy[0], 1'b1);
      check("t2_ready1", rdy[1], 1'b1);
      check("t2_ready2", rdy[2], 1'b0);
      check("t2_ready3", rdy[3], 1'b0);
      res_exp.push_back(res_t'{ch: 16'h0033, hops: 16'h0004, noch: 1'b0, cnt: 16'd2});
      wait_res(2, 10, "t2_early_close");
      check("t2_sel_pulses", 32'(sel_seen - base), 32'd2);

      // empty round: exact latency, no_ch, then held result with res_ready low
      res_ready = 1'b0;
      sel_chosen = 16'h1234; sel_hopsch = 16'h0055;
      hb(16'd0);
      n = 0;
      while (!res_valid && n < 200) begin
         tick();
         n++;
      end
      check("t3_latency", n, T + L);
      check("t3_chosen", chosenCH, 16'hFFFF);
      check("t3_hops", hopsfromCH, 16'hFFFF);
      check("t3_no_ch", no_ch, 1'b1);
      check("t3_count", adv_count, 16'd0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t5_hold_valid", res_valid, 1'b1);
         check("t5_hold_chosen", chosenCH, 16'hFFFF);
         check("t5_hold_no_ch", no_ch, 1'b1);
      end
      res_exp.push_back(res_t'{ch: 16'hFFFF, hops: 16'hFFFF, noch: 1'b1, cnt: 16'd0});
      res_ready = 1'b1;
      wait_res(3, 5, "t5_handshake");
      tick();
      check("t5_res_dropped", res_valid, 1'b0);

      // restart collides with an advert: advert dropped, timer reloaded
      hb(16'd0);
      tick();
      a = ch_info_t'{id: 16'h0041, hops: 16'd3, qvalue: 16'd7};
      sel_exp.push_back(a);
      drive_adv(a);
      tick();
      adv_valid = 1'b0;
      repeat (3) tick();
      hb_start = 1'b1;
      drive_adv(ch_info_t'{id: 16'h0099, hops: 16'd6, qvalue: 16'd6});
      @(negedge clk);
      check("t4_ready_blocked", adv_ready, 1'b0);
      tick();
      hb_start = 1'b0;
      adv_valid = 1'b0;
      res_exp.push_back(res_t'{ch: 16'hFFFF, hops: 16'hFFFF, noch: 1'b1, cnt: 16'd0});
      @(negedge clk);
      check("t4_sel_clear", sel_clear, 1'b1);
      check("t4_sel_en", sel_en, 1'b0);
      check("t4_count", adv_count, 16'd0);
      n = 1;
      tick();
      while (!res_valid && n < 200) begin
         tick();
         n++;
      end
      check("t4_reload_latency", n, T + L);
      wait_res(4, 5, "t4_result_wait");

      // reset with a sel_en on the wire
      res_ready = 1'b0;
      hb(16'd0);
      tick();
      drive_adv(ch_info_t'{id: 16'h0077, hops: 16'd8, qvalue: 16'd9});
      tick();
      adv_valid = 1'b0;
      check("t6_pending", sel_en, 1'b1);
      base = sel_seen;
      nrst = 1'b0;
      #1;
      check("t6_sel_en", sel_en, 1'b0);
      check("t6_sel_clear", sel_clear, 1'b0);
      check("t6_adv_ready", adv_ready, 1'b0);
      check("t6_count", adv_count, 16'd0);
      check("t6_sel_id", sel_id, 16'd0);
      check("t6_res_valid", res_valid, 1'b0);
      check("t6_chosen", chosenCH, 16'hFFFF);
      check("t6_hops", hopsfromCH, 16'hFFFF);
      check("t6_no_ch", no_ch, 1'b0);
      repeat (2) @(posedge clk);
      #1 nrst = 1'b1;
      repeat (10) tick();
      check("t6_no_sel_after", 32'(sel_seen - base), 32'd0);
      check("t6_idle_ready", adv_ready, 1'b0);

      check("sel_queue_empty", sel_exp.size(), 32'd0);
      check("res_queue_empty", res_exp.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
